// File: rtl/loader_pkg.sv
// Shared types and command bytes for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_e;

  localparam logic [7:0] SYNC_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN   = 8'h5A;

endpackage

// File: rtl/loader_timeout.sv
// Saturating idle-cycle counter; expired fires on the increment that reaches LIMIT.
// Latency: expired is combinational from inc and the current count.
// Backpressure: none; clr has priority over inc.
// Ports: clk, reset (async active-low), clr (zero the count), inc (count one idle
//        cycle), expired (this increment reaches LIMIT).
module loader_timeout #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Fires on the edge where the count would become LIMIT, so the owner can
  // act on that same edge rather than one cycle later.
  assign expired = inc && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: parses A5 hi lo len payload csum frames into memory writes; 5A releases the CPU.
// Latency: a payload byte accepted on edge N is written (mem_we) during the cycle after edge N.
// Backpressure: in_ready is high from the first clock after reset; one byte per cycle, never stalls.
// Ports: clk, reset (async active-low); in_data/in_valid/in_ready byte stream; mem_we/mem_addr/
//        mem_wdata write port; cpu_run CPU release; frame_done pulse, csum_err/timeout_err
//        sticky flags; frame_count good-frame counter.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              frame_done,
  output logic              csum_err,
  output logic              timeout_err,
  output logic [7:0]        frame_count
);

  state_e            state_q, state_d;
  logic              xfer;
  logic              expired;
  logic [7:0]        addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        rem_q;     // payload bytes still expected; LEN=0 loads 256
  logic [7:0]        sum_q;     // running sum of hi, lo, len and payload
  logic [7:0]        sum_next;

  assign xfer     = in_valid && in_ready;
  assign sum_next = sum_q + in_data;

  // Idle time only counts inside a frame; any transfer or being in IDLE clears it.
  loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (xfer || (state_q == ST_IDLE)),
    .inc     (!xfer && (state_q != ST_IDLE)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (xfer && (in_data == SYNC_LOAD)) state_d = ST_ADDR_HI;
      ST_ADDR_HI: if (xfer) state_d = ST_ADDR_LO;
      ST_ADDR_LO: if (xfer) state_d = ST_LEN;
      ST_LEN:     if (xfer) state_d = ST_DATA;
      ST_DATA:    if (xfer && (rem_q == 9'd1)) state_d = ST_CSUM;
      ST_CSUM:    if (xfer) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (expired) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      cpu_run     <= 1'b0;
      frame_done  <= 1'b0;
      csum_err    <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= 8'h00;
      addr_hi_q   <= 8'h00;
      addr_q      <= '0;
      rem_q       <= 9'd0;
      sum_q       <= 8'h00;
    end else begin
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      if (xfer) begin
        case (state_q)
          ST_IDLE: begin
            if (in_data == SYNC_LOAD) begin
              cpu_run     <= 1'b0;
              csum_err    <= 1'b0;
              timeout_err <= 1'b0;
              sum_q       <= 8'h00;
            end else if (in_data == CMD_RUN) begin
              cpu_run <= 1'b1;
            end
          end
          ST_ADDR_HI: begin
            addr_hi_q <= in_data;
            sum_q     <= sum_next;
          end
          ST_ADDR_LO: begin
            addr_q <= ADDR_W'({addr_hi_q, in_data});
            sum_q  <= sum_next;
          end
          ST_LEN: begin
            rem_q <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
            sum_q <= sum_next;
          end
          ST_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= in_data;
            addr_q    <= addr_q + ADDR_W'(1);
            rem_q     <= rem_q - 9'd1;
            sum_q     <= sum_next;
          end
          ST_CSUM: begin
            // The CSUM byte completes the sum; a good frame totals zero.
            if (sum_next == 8'h00) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end else begin
              csum_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (expired) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_run;
  logic        frame_done;
  logic        csum_err;
  logic        timeout_err;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_run     (cpu_run),
    .frame_done  (frame_done),
    .csum_err    (csum_err),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          fd_seen = 0;
  int          exp_fd = 0;
  int          gap_max = 0;
  logic [7:0]  exp_fc = 8'h00;
  logic        exp_run = 1'b0;
  logic        exp_cerr = 1'b0;
  logic        exp_terr = 1'b0;
  logic [23:0] wq[$];
  logic [23:0] exp_wq[$];
  logic [7:0]  frm[$];

  // Observe the write port and done pulses mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    if (frame_done === 1'b1) fd_seen++;
  end

  // Called at posedge+1; returns at posedge+1 after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
    #1;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_wait got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Build a frame: sync, address, length, random payload, checksum (optionally corrupted).
  task automatic make_frame(input logic [15:0] a, input int len, input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    frm = {8'hA5, a[15:8], a[7:0], 8'(len)};
    s = a[15:8] + a[7:0] + 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      s = s + b;
    end
    s = 8'h00 - s;
    if (bad) s = s + 8'($urandom_range(1, 255));
    frm.push_back(s);
  endtask

  // Reference model at frame level, then drive bytes frm[first..].
  task automatic apply_frame(input int first);
    int         len;
    logic [15:0] a;
    logic [7:0]  s;
    a   = {frm[1], frm[2]};
    len = (frm[3] == 8'h00) ? 256 : int'(frm[3]);
    s   = 8'h00;
    for (int i = 1; i < frm.size(); i++) s = s + frm[i];
    for (int i = 0; i < len; i++) begin
      exp_wq.push_back({a, frm[4+i]});
      a = a + 16'd1;
    end
    exp_run  = 1'b0;
    exp_terr = 1'b0;
    if (s == 8'h00) begin
      exp_fc = exp_fc + 8'd1;
      exp_fd++;
      exp_cerr = 1'b0;
    end else begin
      exp_cerr = 1'b1;
    end
    for (int i = first; i < frm.size(); i++) send_byte(frm[i]);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    n_cmp++;
    if ({in_ready, mem_we, cpu_run, frame_done, csum_err, timeout_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 000000",
                        {in_ready, mem_we, cpu_run, frame_done, csum_err, timeout_err});
    end
    n_cmp++;
    if ({frame_count, mem_addr, mem_wdata} !== 32'h0) begin
      n_bad++; $display("FAIL reset_values got %h want 0", {frame_count, mem_addr, mem_wdata});
    end
    #9 reset = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL ready_before_clk got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_clk got %b want 1", in_ready);
    end
  endtask

  task automatic test_good_frame();
    wq.delete(); exp_wq.delete();
    frm = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h3E, 8'h55, 8'h6B};
    apply_frame(0);
    n_cmp++;
    if (wq.size() != 2 || wq[0] !== 24'h00003E || wq[1] !== 24'h000155) begin
      n_bad++; $display("FAIL good_writes got n=%0d w0=%h want 00003e,000155", wq.size(),
                        (wq.size() > 0) ? wq[0] : 24'hx);
    end
    n_cmp++;
    if (fd_seen != exp_fd || frame_count !== exp_fc) begin
      n_bad++; $display("FAIL good_done got fd=%0d fc=%0d want fd=%0d fc=%0d",
                        fd_seen, frame_count, exp_fd, exp_fc);
    end
    n_cmp++;
    if (csum_err !== 1'b0) begin
      n_bad++; $display("FAIL good_csum_err got %b want 0", csum_err);
    end
  endtask

  task automatic test_bad_csum();
    wq.delete(); exp_wq.delete();
    frm = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h3E, 8'h55, 8'h6C};
    apply_frame(0);
    n_cmp++;
    if (wq.size() != exp_wq.size() || wq[0] !== exp_wq[0] || wq[1] !== exp_wq[1]) begin
      n_bad++; $display("FAIL bad_writes got n=%0d want n=%0d", wq.size(), exp_wq.size());
    end
    n_cmp++;
    if (csum_err !== 1'b1 || fd_seen != exp_fd || frame_count !== exp_fc) begin
      n_bad++; $display("FAIL bad_flags got cerr=%b fd=%0d fc=%0d want cerr=1 fd=%0d fc=%0d",
                        csum_err, fd_seen, frame_count, exp_fd, exp_fc);
    end
    make_frame(16'h1234, 3, 1'b0);
    apply_frame(0);
    n_cmp++;
    if (csum_err !== 1'b0 || frame_count !== exp_fc) begin
      n_bad++; $display("FAIL bad_then_good got cerr=%b fc=%0d want cerr=0 fc=%0d",
                        csum_err, frame_count, exp_fc);
    end
  endtask

  task automatic test_addr_wrap();
    wq.delete(); exp_wq.delete();
    frm = {8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCD};
    apply_frame(0);
    n_cmp++;
    if (wq.size() != 2 || wq[0] !== 24'hFFFF11 || wq[1] !== 24'h000022) begin
      n_bad++; $display("FAIL wrap_writes got n=%0d w1=%h want ffff11,000022", wq.size(),
                        (wq.size() > 1) ? wq[1] : 24'hx);
    end
    n_cmp++;
    if (fd_seen != exp_fd || frame_count !== exp_fc) begin
      n_bad++; $display("FAIL wrap_done got fd=%0d fc=%0d want fd=%0d fc=%0d",
                        fd_seen, frame_count, exp_fd, exp_fc);
    end
  endtask

  task automatic test_run_control();
    wq.delete(); exp_wq.delete();
    send_byte(8'h5A);
    n_cmp++;
    if (cpu_run !== 1'b1) begin
      n_bad++; $display("FAIL run_set got %b want 1", cpu_run);
    end
    send_byte(8'h33);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (cpu_run !== 1'b1 || wq.size() != 0 || frame_count !== exp_fc) begin
      n_bad++; $display("FAIL stray_byte got run=%b nw=%0d fc=%0d want run=1 nw=0 fc=%0d",
                        cpu_run, wq.size(), frame_count, exp_fc);
    end
    make_frame(16'h0040, 1, 1'b0);
    send_byte(8'hA5);
    n_cmp++;
    if (cpu_run !== 1'b0) begin
      n_bad++; $display("FAIL run_clear got %b want 0", cpu_run);
    end
    apply_frame(1);
    n_cmp++;
    if (wq.size() != 1 || wq[0] !== exp_wq[0] || frame_count !== exp_fc) begin
      n_bad++; $display("FAIL run_frame got nw=%0d fc=%0d want nw=1 fc=%0d",
                        wq.size(), frame_count, exp_fc);
    end
  endtask

  task automatic test_timeout();
    wq.delete(); exp_wq.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    repeat (TO - 1) @(posedge clk);
    #1;
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early got %b want 0", timeout_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (timeout_err !== 1'b1 || wq.size() != 0) begin
      n_bad++; $display("FAIL timeout_set got terr=%b nw=%0d want terr=1 nw=0",
                        timeout_err, wq.size());
    end
    make_frame(16'h0500, 2, 1'b0);
    apply_frame(0);
    n_cmp++;
    if (timeout_err !== 1'b0 || wq.size() != 2 || wq[0] !== exp_wq[0] ||
        wq[1] !== exp_wq[1] || fd_seen != exp_fd) begin
      n_bad++; $display("FAIL timeout_recover got terr=%b nw=%0d fd=%0d want terr=0 nw=2 fd=%0d",
                        timeout_err, wq.size(), fd_seen, exp_fd);
    end
  endtask

  task automatic test_len_zero();
    int errs;
    wq.delete(); exp_wq.delete();
    make_frame(16'($urandom), 256, 1'b0);
    apply_frame(0);
    errs = 0;
    for (int i = 0; i < 256 && i < wq.size(); i++) if (wq[i] !== exp_wq[i]) errs++;
    n_cmp++;
    if (wq.size() != 256 || errs != 0) begin
      n_bad++; $display("FAIL len0_writes got n=%0d bad=%0d want n=256 bad=0", wq.size(), errs);
    end
    n_cmp++;
    if (fd_seen != exp_fd || frame_count !== exp_fc || csum_err !== 1'b0) begin
      n_bad++; $display("FAIL len0_done got fd=%0d fc=%0d cerr=%b want fd=%0d fc=%0d cerr=0",
                        fd_seen, frame_count, csum_err, exp_fd, exp_fc);
    end
  endtask

  task automatic test_random_frames();
    int errs;
    gap_max = 3;
    for (int f = 0; f < 12; f++) begin
      wq.delete(); exp_wq.delete();
      make_frame(16'($urandom), $urandom_range(1, 16), ($urandom_range(0, 2) == 0));
      apply_frame(0);
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'h5A);
        exp_run = 1'b1;
        @(posedge clk); #1;
      end
      errs = 0;
      for (int i = 0; i < exp_wq.size() && i < wq.size(); i++) if (wq[i] !== exp_wq[i]) errs++;
      n_cmp++;
      if (wq.size() != exp_wq.size() || errs != 0) begin
        n_bad++; $display("FAIL rand%0d_writes got n=%0d bad=%0d want n=%0d bad=0",
                          f, wq.size(), errs, exp_wq.size());
      end
      n_cmp++;
      if (frame_count !== exp_fc || fd_seen != exp_fd || csum_err !== exp_cerr ||
          cpu_run !== exp_run || timeout_err !== exp_terr) begin
        n_bad++; $display("FAIL rand%0d_state got fc=%0d fd=%0d cerr=%b run=%b want fc=%0d fd=%0d cerr=%b run=%b",
                          f, frame_count, fd_seen, csum_err, cpu_run, exp_fc, exp_fd, exp_cerr, exp_run);
      end
    end
    gap_max = 0;
  endtask

  task automatic test_reset_mid_data();
    wq.delete(); exp_wq.delete();
    make_frame(16'h0020, 3, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(frm[i]);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== frm[4]) begin
      n_bad++; $display("FAIL first_write got we=%b a=%h d=%h want we=1 a=0020 d=%h",
                        mem_we, mem_addr, mem_wdata, frm[4]);
    end
    reset = 1'b0;
    #1;
    exp_fc = 8'h00; exp_run = 1'b0; exp_cerr = 1'b0; exp_terr = 1'b0;
    n_cmp++;
    if ({in_ready, mem_we, cpu_run, frame_done, csum_err, timeout_err, frame_count} !== 14'h0) begin
      n_bad++; $display("FAIL mid_reset got %b want all zero",
                        {in_ready, mem_we, cpu_run, frame_done, csum_err, timeout_err, frame_count});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (wq.size() != 0 || frame_count !== exp_fc || cpu_run !== exp_run) begin
      n_bad++; $display("FAIL post_reset got nw=%0d fc=%0d run=%b want nw=0 fc=0 run=0",
                        wq.size(), frame_count, cpu_run);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_addr_wrap();
    test_run_control();
    test_timeout();
    test_len_zero();
    test_random_frames();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that sits upstream of `cpu_top` and its program/data memory. It parses framed load commands from a serial-style valid/ready byte stream and writes the payload into memory through a single write port. It holds the CPU in reset until a run command arrives. It reports checksum and timeout errors so a host or bench can retry a frame.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width; addresses wrap modulo 2^ADDR_W.
- `TIMEOUT_CYCLES`, 1024: maximum number of idle cycles allowed between bytes inside a frame.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_data`, input, 8: incoming stream byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader can accept a byte; a byte transfers when `in_valid && in_ready`.
- `mem_we`, output, 1: one-cycle write strobe.
- `mem_addr`, output, ADDR_W: write address.
- `mem_wdata`, output, 8: write data.
- `cpu_run`, output, 1: high releases the CPU; low holds it in reset.
- `frame_done`, output, 1: one-cycle pulse when a frame ends with a good checksum.
- `csum_err`, output, 1: sticky flag for a bad checksum.
- `timeout_err`, output, 1: sticky flag for a mid-frame stall.
- `frame_count`, output, 8: count of good frames; wraps from 0xFF to 0x00.

## Operation
- Reset value of every output is 0, including `in_ready`. `in_ready` rises on the first clock after reset deasserts and stays high thereafter.
- The state machine has six states: IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM.
- IDLE transitions:
  - 0xA5 (load): clear `cpu_run`, `csum_err` and `timeout_err`, then go to ADDR_HI.
  - 0x5A (run): set `cpu_run`, stay in IDLE.
  - Any other byte is discarded with no effect.
- ADDR_HI, then ADDR_LO, latch the start address. LEN latches the payload length; a LEN byte of 0 means 256 bytes. After LEN, go to DATA.
- DATA: each accepted byte is written to the current address, then the address increments, wrapping from 0xFFFF to 0x0000. When the remaining count reaches 0, go to CSUM.
- Checksum rule: the 8-bit sum of addr_hi + addr_lo + len + every payload byte + the CSUM byte must equal 0x00, modulo 256.
- CSUM: if the sum is 0x00, pulse `frame_done` and increment `frame_count`. Otherwise set `csum_err`. Either way, return to IDLE.
- Payload writes are not rolled back on a checksum error; the host re-sends the frame.
- Timeout: in any state other than IDLE, a counter increments on each cycle with no transfer and clears on every transfer. When it reaches `TIMEOUT_CYCLES`, set `timeout_err` and return to IDLE with no further writes.
- Asserting reset mid-frame immediately clears all state and outputs, and the in-flight `mem_we` is dropped.

## Timing
- A byte accepted on edge N produces its write on the following cycle: `mem_we`=1 with `mem_addr`/`mem_wdata` registered, valid between edges N and N+1. The loader supports one transfer per cycle with no bubbles.
- `cpu_run` changes on the edge that accepts the 0x5A or 0xA5 byte.
- `frame_done`, the `frame_count` update and `csum_err` all take effect on the edge that accepts the CSUM byte.
- `timeout_err` sets on the edge where the idle-cycle count reaches `TIMEOUT_CYCLES`.
- A frame of length L takes exactly L+5 accepted bytes.

## Structure
- A shared package `loader_pkg` holds the state enum and the constants `SYNC_LOAD`=0xA5 and `CMD_RUN`=0x5A.
- The natural sub-module is `loader_timeout`, a resettable saturating counter with an `expired` output. Frame parsing, the checksum accumulator and the address counter stay in the top module.

## Test plan
- Good frame: send A5 00 00 02 3E 55 6B → writes 0x0000=0x3E and 0x0001=0x55, `frame_done` pulses once, `frame_count`=1, `csum_err`=0.
- Bad checksum: send A5 00 00 02 3E 55 6C → both writes still occur, `csum_err`=1, no `frame_done`, `frame_count` unchanged. A following good frame clears `csum_err`.
- Address wrap: send A5 FF FF 02 11 22 CD → writes 0xFFFF=0x11 then 0x0000=0x22, `frame_done`.
- Run control: 5A in IDLE → `cpu_run`=1 on the next edge. A following A5 → `cpu_run`=0; a stray 0x33 in IDLE changes nothing.
- Timeout: send A5 00 10 03 then hold `in_valid`=0 for `TIMEOUT_CYCLES` cycles → `timeout_err`=1, state returns to IDLE. A later A5 starts a fresh frame.
- Reset mid-DATA and LEN=0: drop reset after 1 of 3 payload bytes → all outputs 0, no further writes. A LEN=0 frame accepts exactly 256 payload bytes before CSUM.
